serial_to_parallel_lane: RTL and testbench

//  Per-lane receive deserializer directly upstream of byte un-striping.
//  - Converts the 1-bit serial lane stream into 32-bit words plus a valid flag.
//  - Aligns to byte boundaries by searching for the COMMA (BC) symbol.
//  - Declares the lane active after LOCK_COUNT consecutive aligned commas.
//  - One instance per lane drives lane_0/valid_0 and lane_1/valid_1 of the un-striping stage.

---
 rtl/serial_to_parallel_lane_pkg.sv | 16 +
 rtl/serial_to_parallel_lane.sv | 158 +++++++++++++++
 tb/tb_serial_to_parallel_lane.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/serial_to_parallel_lane_pkg.sv
// Shared lane-receive definitions: control symbols, default sizes and the
// alignment FSM state encoding used by the serial-to-parallel lane.
package serial_to_parallel_lane_pkg;

  localparam int         WORD_W_DEF     = 32;
  localparam int         LOCK_COUNT_DEF = 4;
  localparam logic [7:0] COMMA_SYM      = 8'hBC;
  localparam logic [7:0] IDLE_SYM       = 8'h7C;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ALIGNING = 2'd1,
    ST_LOCKED   = 2'd2
  } lane_state_t;

endpackage

// File: rtl/serial_to_parallel_lane.sv
// Per-lane receive deserializer. Finds byte alignment by hunting for the
// COMMA symbol, confirms it with LOCK_COUNT consecutive aligned commas, then
// assembles MSB-first bytes into WORD_W-bit words. Words carrying a COMMA or
// IDLE byte are control, not data, and leave lane_out untouched.
//
// Handshake: o_valid_out/o_lane_out change only on the edge that samples the
// last bit of a word and then hold for WORD_W cycles; o_valid_out=1 means
// o_lane_out holds a data word. There is no back-pressure.
module serial_to_parallel_lane
  import serial_to_parallel_lane_pkg::*;
#(
  parameter int         WORD_W     = WORD_W_DEF,   // multiple of 8
  parameter logic [7:0] COMMA      = COMMA_SYM,
  parameter logic [7:0] IDLE       = IDLE_SYM,
  parameter int         LOCK_COUNT = LOCK_COUNT_DEF // >= 1
) (
  input  logic              i_clk_32f,
  input  logic              i_reset,
  input  logic              i_serial_in,
  output logic              o_active,
  output logic              o_valid_out,
  output logic [WORD_W-1:0] o_lane_out,
  output logic [1:0]        o_dbg_state
);

  localparam int NBYTES = WORD_W / 8;
  localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int CW     = $clog2(LOCK_COUNT + 1);

  localparam logic [BW-1:0] LAST_BYTE = BW'(NBYTES - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_COUNT - 1);

  // Only the WORD_W-1 most recent bits are ever needed: the current input
  // bit completes both the byte window and the word.
  lane_state_t       r_state;
  logic [WORD_W-2:0] r_sh;
  logic [2:0]        r_bit_cnt;
  logic [BW-1:0]     r_byte_cnt;
  logic [CW-1:0]     r_comma_cnt;
  logic              r_valid_out;
  logic [WORD_W-1:0] r_lane_out;

  lane_state_t       w_state_nxt;
  logic [2:0]        w_bit_cnt_nxt;
  logic [BW-1:0]     w_byte_cnt_nxt;
  logic [CW-1:0]     w_comma_cnt_nxt;
  logic [WORD_W-1:0] w_word;
  logic [7:0]        w_nxt_byte;
  logic              w_word_done;
  logic              w_word_is_data;

  assign w_word     = {r_sh, i_serial_in};
  assign w_nxt_byte = w_word[7:0];

  // A word is data only if none of its bytes is a control symbol.
  always_comb begin
    w_word_is_data = 1'b1;
    for (int b = 0; b < NBYTES; b++) begin
      if (w_word[8*b +: 8] == COMMA || w_word[8*b +: 8] == IDLE) begin
        w_word_is_data = 1'b0;
      end
    end
  end

  // Alignment FSM next-state and counter updates.
  always_comb begin
    w_state_nxt     = r_state;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_byte_cnt_nxt  = r_byte_cnt;
    w_comma_cnt_nxt = r_comma_cnt;
    w_word_done     = 1'b0;
    case (r_state)
      ST_UNLOCKED: begin
        w_bit_cnt_nxt   = '0;
        w_byte_cnt_nxt  = '0;
        w_comma_cnt_nxt = '0;
        if (w_nxt_byte == COMMA) begin
          if (LOCK_COUNT == 1) begin
            w_state_nxt = ST_LOCKED;
          end else begin
            w_state_nxt     = ST_ALIGNING;
            w_comma_cnt_nxt = CW'(1);
          end
        end
      end
      ST_ALIGNING: begin
        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) begin
          if (w_nxt_byte == COMMA) begin
            if (r_comma_cnt == LOCK_LAST) begin
              w_state_nxt    = ST_LOCKED;
              w_bit_cnt_nxt  = '0;
              w_byte_cnt_nxt = '0;
            end else begin
              w_comma_cnt_nxt = r_comma_cnt + CW'(1);
            end
          end else begin
            // Comma seen at bit level was not repeated on the byte grid.
            w_state_nxt     = ST_UNLOCKED;
            w_comma_cnt_nxt = '0;
          end
        end
      end
      ST_LOCKED: begin
        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) begin
          if (r_byte_cnt == LAST_BYTE) begin
            w_byte_cnt_nxt = '0;
            w_word_done    = 1'b1;
          end else begin
            w_byte_cnt_nxt = r_byte_cnt + BW'(1);
          end
        end
      end
      default: begin
        w_state_nxt = ST_UNLOCKED;
      end
    endcase
  end

  // State, shift register and counters.
  always_ff @(posedge i_clk_32f) begin
    if (i_reset) begin
      r_state     <= ST_UNLOCKED;
      r_sh        <= '0;
      r_bit_cnt   <= '0;
      r_byte_cnt  <= '0;
      r_comma_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sh        <= w_word[WORD_W-2:0];
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_byte_cnt  <= w_byte_cnt_nxt;
      r_comma_cnt <= w_comma_cnt_nxt;
    end
  end

  // Output word register: updated only at word completion.
  always_ff @(posedge i_clk_32f) begin
    if (i_reset) begin
      r_valid_out <= 1'b0;
      r_lane_out  <= '0;
    end else if (w_word_done) begin
      if (w_word_is_data) begin
        r_valid_out <= 1'b1;
        r_lane_out  <= w_word;
      end else begin
        r_valid_out <= 1'b0;
      end
    end
  end

  assign o_active    = (r_state == ST_LOCKED);
  assign o_valid_out = r_valid_out;
  assign o_lane_out  = r_lane_out;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_serial_to_parallel_lane.sv
// Bench for serial_to_parallel_lane: directed bit streams, expected output
// states queued by the driver, checked every cycle by an independent monitor.
module tb_serial_to_parallel_lane;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        serial_in = 1'b0;
  logic        active;
  logic        valid_out;
  logic [31:0] lane_out;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  serial_to_parallel_lane dut (
    .i_clk_32f   (clk),
    .i_reset     (reset),
    .i_serial_in (serial_in),
    .o_active    (active),
    .o_valid_out (valid_out),
    .o_lane_out  (lane_out),
    .o_dbg_state (dbg_state)
  );

  // {active, valid_out, lane_out} expected after the next clock edge
  logic [33:0] exp_q[$];
  int          checks = 0;
  int          failures = 0;

  logic        exp_active = 1'b0;
  logic        exp_valid  = 1'b0;
  logic [31:0] exp_lane   = 32'h0;

  // Drive one bit (and reset level) for the next rising edge.
  task automatic tick(input logic b, input logic r);
    @(posedge clk);
    #2;
    serial_in = b;
    reset     = r;
  endtask

  task automatic push_exp();
    exp_q.push_back({exp_active, exp_valid, exp_lane});
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) tick(v[i], 1'b0);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) tick(w[i], 1'b0);
  endtask

  function automatic logic is_data(input logic [31:0] w);
    logic d;
    d = 1'b1;
    for (int b = 0; b < 4; b++) begin
      if (w[8*b +: 8] == 8'hBC || w[8*b +: 8] == 8'h7C) d = 1'b0;
    end
    return d;
  endfunction

  // Locked word: data updates lane_out, control only drops valid.
  task automatic send_locked(input logic [31:0] w);
    send_word(w);
    if (is_data(w)) begin
      exp_valid = 1'b1;
      exp_lane  = w;
    end else begin
      exp_valid = 1'b0;
    end
    push_exp();
  endtask

  // Four commas; active rises on the edge taking the last comma bit.
  task automatic lock_seq();
    repeat (4) send_byte(8'hBC);
    exp_active = 1'b1;
    push_exp();
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      tick(i[0], 1'b1);
      exp_active = 1'b0;
      exp_valid  = 1'b0;
      exp_lane   = 32'h0;
      push_exp();
    end
  endtask

  // Monitor: on a queued update compare against it, otherwise the outputs
  // must hold the last expected state.
  initial begin
    logic [33:0] cur;
    logic [33:0] act;
    logic        have;
    string       kind;
    have = 1'b0;
    cur  = '0;
    forever begin
      @(posedge clk);
      #1;
      act = {active, valid_out, lane_out};
      if (exp_q.size() > 0) begin
        cur  = exp_q.pop_front();
        have = 1'b1;
        kind = "update";
      end else begin
        kind = "hold";
      end
      if (have) begin
        checks++;
        if (act !== cur) begin
          failures++;
          $display("FAIL %s t=%0t got active=%b valid=%b lane=%h want active=%b valid=%b lane=%h",
                   kind, $time, act[33], act[32], act[31:0], cur[33], cur[32], cur[31:0]);
        end
      end
    end
  end

  logic [31:0] cut_word;
  logic [31:0] words [8];

  initial begin
    words[0] = 32'h00000001; words[1] = 32'h80000000;
    words[2] = 32'hFFFFFFFF; words[3] = 32'h12345678;
    words[4] = 32'hCAFEF00D; words[5] = 32'h0F0F0F0F;
    words[6] = 32'hA5A5A5A5; words[7] = 32'h55AA33CC;

    // 1: reset held with serial_in toggling
    do_reset(5);

    // 2: lock at a 3-bit offset, then one data word
    tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b1, 1'b0);
    lock_seq();
    send_locked(32'hDEADBEEF);

    // 3: false comma run broken by 8'h11, then relock
    do_reset(1);
    send_byte(8'hBC); send_byte(8'hBC); send_byte(8'h11);
    lock_seq();
    send_locked(32'h01020304);

    // 4: data then control words
    send_locked(32'hAABBCCDD);
    send_locked(32'hBCBCBCBC);
    send_locked(32'h7C000000);

    // 5: reset at bit 17 of a locked word; no data until relocked
    cut_word = 32'hF0F0F0F0;
    for (int i = 31; i > 14; i--) tick(cut_word[i], 1'b0);
    tick(cut_word[14], 1'b1);
    exp_active = 1'b0; exp_valid = 1'b0; exp_lane = 32'h0;
    push_exp();
    for (int i = 13; i >= 0; i--) tick(cut_word[i], 1'b0);
    send_word(32'h12345678);
    lock_seq();

    // 6: back-to-back data words, each must hold for 32 cycles
    for (int k = 0; k < 8; k++) send_locked(words[k]);

    repeat (10) tick(1'b0, 1'b0);
    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got pending=%0d want pending=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
